// File: rtl/sdf_bf_stage.sv
// Radix-2 SDF butterfly stage: DEPTH-entry complex delay line, add/sub and twiddle rotate.
// Define FFT_SAT_EN to saturate add, sub and rounded multiply results instead of wrapping.
module sdf_bf_stage #(
  parameter int DW    = 24,
  parameter int DEPTH = 4,
  parameter int FRAC  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  localparam int PW = 2*DW + 1;
  localparam logic signed [PW-1:0] L_RND = PW'(1 << (FRAC-1));

  logic [DW-1:0] r_dl_r [DEPTH];
  logic [DW-1:0] r_dl_i [DEPTH];
  logic          r_ov;
  logic [DW-1:0] r_do_r;
  logic [DW-1:0] r_do_i;

  logic w_st_fill;
  logic w_st_bfly;
  logic w_st_rot;
  logic w_push;

  assign w_st_fill = (state == 2'd0);
  assign w_st_bfly = (state == 2'd1);
  assign w_st_rot  = (state == 2'd2);
  assign w_push    = in_valid & (w_st_fill | w_st_bfly | w_st_rot);

  logic signed [DW-1:0] w_hr;
  logic signed [DW-1:0] w_hi;
  logic signed [DW-1:0] w_dr;
  logic signed [DW-1:0] w_di;
  logic signed [DW-1:0] w_wr;
  logic signed [DW-1:0] w_wi;

  assign w_hr = $signed(r_dl_r[0]);
  assign w_hi = $signed(r_dl_i[0]);
  assign w_dr = $signed(din_r);
  assign w_di = $signed(din_i);
  assign w_wr = $signed(w_r);
  assign w_wi = $signed(w_i);

  // Full-precision intermediates; narrowing happens in one place below.
  logic signed [PW-1:0] w_add_r;
  logic signed [PW-1:0] w_add_i;
  logic signed [PW-1:0] w_sub_r;
  logic signed [PW-1:0] w_sub_i;
  logic signed [PW-1:0] w_prod_r;
  logic signed [PW-1:0] w_prod_i;
  logic signed [PW-1:0] w_mul_r;
  logic signed [PW-1:0] w_mul_i;

  assign w_add_r = PW'(w_hr) + PW'(w_dr);
  assign w_add_i = PW'(w_hi) + PW'(w_di);
  assign w_sub_r = PW'(w_hr) - PW'(w_dr);
  assign w_sub_i = PW'(w_hi) - PW'(w_di);

  assign w_prod_r = PW'(w_hr) * PW'(w_wr)
                  - PW'(w_hi) * PW'(w_wi) + L_RND;
  assign w_prod_i = PW'(w_hr) * PW'(w_wi)
                  + PW'(w_hi) * PW'(w_wr) + L_RND;
  assign w_mul_r  = w_prod_r >>> FRAC;
  assign w_mul_i  = w_prod_i >>> FRAC;

  logic [DW-1:0] w_add_fr;
  logic [DW-1:0] w_add_fi;
  logic [DW-1:0] w_sub_fr;
  logic [DW-1:0] w_sub_fi;
  logic [DW-1:0] w_mul_fr;
  logic [DW-1:0] w_mul_fi;
  logic          w_unused;

`ifdef FFT_SAT_EN
  localparam logic signed [PW-1:0] L_MAX =
    {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] L_MIN =
    {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] f_sat(
    input logic signed [PW-1:0] v
  );
    logic [DW-1:0] res;
    if (v > L_MAX)
      res = L_MAX[DW-1:0];
    else if (v < L_MIN)
      res = L_MIN[DW-1:0];
    else
      res = v[DW-1:0];
    return res;
  endfunction

  assign w_add_fr = f_sat(w_add_r);
  assign w_add_fi = f_sat(w_add_i);
  assign w_sub_fr = f_sat(w_sub_r);
  assign w_sub_fi = f_sat(w_sub_i);
  assign w_mul_fr = f_sat(w_mul_r);
  assign w_mul_fi = f_sat(w_mul_i);
  assign w_unused = ^{w_prod_r[FRAC-1:0], w_prod_i[FRAC-1:0]};
`else
  assign w_add_fr = w_add_r[DW-1:0];
  assign w_add_fi = w_add_i[DW-1:0];
  assign w_sub_fr = w_sub_r[DW-1:0];
  assign w_sub_fi = w_sub_i[DW-1:0];
  assign w_mul_fr = w_mul_r[DW-1:0];
  assign w_mul_fi = w_mul_i[DW-1:0];
  assign w_unused = ^{w_add_r[PW-1:DW], w_add_i[PW-1:DW],
                      w_sub_r[PW-1:DW], w_sub_i[PW-1:DW],
                      w_mul_r[PW-1:DW], w_mul_i[PW-1:DW],
                      w_prod_r[FRAC-1:0], w_prod_i[FRAC-1:0]};
`endif

  // Butterfly feeds the difference back; fill and rotate feed the raw sample.
  logic [DW-1:0] w_pv_r;
  logic [DW-1:0] w_pv_i;

  assign w_pv_r = w_st_bfly ? w_sub_fr : din_r;
  assign w_pv_i = w_st_bfly ? w_sub_fi : din_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dl_r[i] <= '0;
        r_dl_i[i] <= '0;
      end
    end else if (w_push) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        r_dl_r[i] <= r_dl_r[i+1];
        r_dl_i[i] <= r_dl_i[i+1];
      end
      r_dl_r[DEPTH-1] <= w_pv_r;
      r_dl_i[DEPTH-1] <= w_pv_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov   <= 1'b0;
      r_do_r <= '0;
      r_do_i <= '0;
    end else begin
      r_ov <= 1'b0;
      if (in_valid) begin
        unique case (1'b1)
          w_st_bfly: begin
            r_do_r <= w_add_fr;
            r_do_i <= w_add_fi;
            r_ov   <= 1'b1;
          end
          w_st_rot: begin
            r_do_r <= w_mul_fr;
            r_do_i <= w_mul_fi;
            r_ov   <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign out_valid = r_ov;
  assign dout_r    = r_do_r;
  assign dout_i    = r_do_i;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Self-checking bench for sdf_bf_stage: directed steps plus random frames
// compared against a queue-based arithmetic model of the stage.
module tb_sdf_bf_stage;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int FRAC  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] din_r;
  logic [DW-1:0] din_i;
  logic [1:0]    state;
  logic [DW-1:0] w_r;
  logic [DW-1:0] w_i;
  logic          out_valid;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] dout_i;

  int checks   = 0;
  int failures = 0;
  bit gap_en   = 0;

  sdf_bf_stage #(.DW(DW), .DEPTH(DEPTH), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  // Reference model: delay line as queues of integers, plain arithmetic.
  longint q_r[$];
  longint q_i[$];
  bit     m_ov;
  longint m_dr;
  longint m_di;

  function automatic longint sx(input logic [DW-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint fit(input longint v);
    longint lo;
    longint hi;
    longint m;
    lo = -(longint'(1) << (DW-1));
    hi = (longint'(1) << (DW-1)) - 1;
`ifdef FFT_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    m = v & ((longint'(1) << DW) - 1);
    if (m > hi) m = m - (longint'(1) << DW);
    return m;
`endif
  endfunction

  task automatic model_reset();
    q_r.delete();
    q_i.delete();
    for (int k = 0; k < DEPTH; k++) begin
      q_r.push_back(0);
      q_i.push_back(0);
    end
    m_ov = 0;
    m_dr = 0;
    m_di = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] st,
                            input longint dr, input longint di,
                            input longint wr, input longint wi);
    longint hr;
    longint hi;
    m_ov = 0;
    if (v) begin
      hr = q_r[0];
      hi = q_i[0];
      case (st)
        2'd0: begin
          void'(q_r.pop_front()); void'(q_i.pop_front());
          q_r.push_back(dr); q_i.push_back(di);
        end
        2'd1: begin
          m_dr = fit(hr + dr);
          m_di = fit(hi + di);
          m_ov = 1;
          void'(q_r.pop_front()); void'(q_i.pop_front());
          q_r.push_back(fit(hr - dr)); q_i.push_back(fit(hi - di));
        end
        2'd2: begin
          m_dr = fit((hr*wr - hi*wi + (longint'(1) << (FRAC-1))) >>> FRAC);
          m_di = fit((hr*wi + hi*wr + (longint'(1) << (FRAC-1))) >>> FRAC);
          m_ov = 1;
          void'(q_r.pop_front()); void'(q_i.pop_front());
          q_r.push_back(dr); q_i.push_back(di);
        end
        default: begin
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input logic [1:0] st,
                      input logic [DW-1:0] dr, input logic [DW-1:0] di,
                      input logic [DW-1:0] wr, input logic [DW-1:0] wi);
    logic [DW-1:0] er;
    logic [DW-1:0] ei;
    @(negedge clk);
    in_valid = v; state = st;
    din_r = dr; din_i = di; w_r = wr; w_i = wi;
    model_step(v, st, sx(dr), sx(di), sx(wr), sx(wi));
    @(posedge clk);
    #1;
    er = m_dr[DW-1:0];
    ei = m_di[DW-1:0];
    check("model_ov", 32'(out_valid), 32'(m_ov));
    check("model_dr", 32'(dout_r), 32'(er));
    check("model_di", 32'(dout_i), 32'(ei));
  endtask

  task automatic gap();
    int n;
    if (gap_en) begin
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++)
        step(0, 2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom),
             24'($urandom), 24'($urandom));
    end
  endtask

  task automatic gstep(input logic [1:0] st,
                       input logic [DW-1:0] dr, input logic [DW-1:0] di,
                       input logic [DW-1:0] wr, input logic [DW-1:0] wi);
    gap();
    step(1, st, dr, di, wr, wi);
  endtask

  task automatic kexp(input string tag, input logic [DW-1:0] er,
                      input logic [DW-1:0] ei);
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_r"}, 32'(dout_r), 32'(er));
    check({tag, "_i"}, 32'(dout_i), 32'(ei));
  endtask

  task automatic t2_t3();
    logic [DW-1:0] tw_r [4];
    logic [DW-1:0] tw_i [4];
    logic [DW-1:0] ex_r [4];
    logic [DW-1:0] ex_i [4];
    tw_r = '{24'(256), 24'(181), 24'(0), 24'(-181)};
    tw_i = '{24'(0), 24'(-181), 24'(-256), 24'(-181)};
    ex_r = '{24'(256), 24'(362), 24'(0), 24'(-724)};
    ex_i = '{24'(0), 24'(-362), 24'(-768), 24'(-724)};
    for (int k = 0; k < 4; k++) begin
      gstep(2'd0, 24'(256*(k+1)), 24'(0), 24'(0), 24'(0));
      check("t2_fill_ov", 32'(out_valid), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      gstep(2'd1, 24'(0), 24'(0), 24'($urandom), 24'($urandom));
      kexp("t2_bfly", 24'(256*(k+1)), 24'(0));
    end
    for (int k = 0; k < 4; k++) begin
      gstep(2'd2, 24'(0), 24'(0), tw_r[k], tw_i[k]);
      kexp("t3_rot", ex_r[k], ex_i[k]);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    if ($urandom_range(0, 1) == 0)
      return 24'(int'($urandom_range(0, 8191)) - 4096);
    return 24'($urandom);
  endfunction

  function automatic logic [DW-1:0] rnd_tw();
    if ($urandom_range(0, 3) == 0)
      return 24'($urandom);
    return 24'(int'($urandom_range(0, 512)) - 256);
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; state = 0;
    din_r = 0; din_i = 0; w_r = 0; w_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_dr", 32'(dout_r), 32'd0);
    check("rst_di", 32'(dout_i), 32'd0);
    rst_n = 1;

    // Fill + butterfly + rotate, first back-to-back then with gaps.
    t2_t3();
    gap_en = 1;
    t2_t3();
    gap_en = 0;

    // Rounding: head (1,0)*181 -> 1, head (-1,0)*128 -> 0.
    step(1, 2'd0, 24'(1), 24'(0), 24'(0), 24'(0));
    step(1, 2'd0, 24'(-1), 24'(0), 24'(0), 24'(0));
    step(1, 2'd0, 24'(0), 24'(0), 24'(0), 24'(0));
    step(1, 2'd0, 24'(0), 24'(0), 24'(0), 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(181), 24'(0));
    kexp("t4_rnd_pos", 24'(1), 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(128), 24'(0));
    kexp("t4_rnd_neg", 24'(0), 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(0), 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(0), 24'(0));

    // Overflow of sum, then of the pushed difference (read back via unity twiddle).
    step(1, 2'd0, 24'h7FFFFF, 24'(0), 24'(0), 24'(0));
    step(1, 2'd0, 24'h800000, 24'(0), 24'(0), 24'(0));
    step(1, 2'd0, 24'(0), 24'(0), 24'(0), 24'(0));
    step(1, 2'd0, 24'(0), 24'(0), 24'(0), 24'(0));
    step(1, 2'd1, 24'(1), 24'(0), 24'(0), 24'(0));
`ifdef FFT_SAT_EN
    kexp("t6_sum_ovf", 24'h7FFFFF, 24'(0));
`else
    kexp("t6_sum_ovf", 24'h800000, 24'(0));
`endif
    step(1, 2'd1, 24'(1), 24'(0), 24'(0), 24'(0));
    kexp("t6_sum_neg", 24'h800001, 24'(0));
    step(1, 2'd1, 24'(1), 24'(0), 24'(0), 24'(0));
    step(1, 2'd1, 24'(1), 24'(0), 24'(0), 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(256), 24'(0));
    kexp("t6_diff_ok", 24'h7FFFFE, 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(256), 24'(0));
`ifdef FFT_SAT_EN
    kexp("t6_diff_ovf", 24'h800000, 24'(0));
`else
    kexp("t6_diff_ovf", 24'h7FFFFF, 24'(0));
`endif
    step(1, 2'd2, 24'(0), 24'(0), 24'(256), 24'(0));
    step(1, 2'd2, 24'(0), 24'(0), 24'(256), 24'(0));

    // Illegal phase: no push, no output, dout holds.
    step(1, 2'd3, 24'(77), 24'(77), 24'(0), 24'(0));
    check("st3_ov", 32'(out_valid), 32'd0);

    // Random frames with gaps and stray illegal phases.
    gap_en = 1;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < DEPTH; k++)
        gstep(2'd0, rnd_data(), rnd_data(), rnd_tw(), rnd_tw());
      for (int r = 0; r < 2; r++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if ($urandom_range(0, 7) == 0)
            step(1, 2'd3, rnd_data(), rnd_data(), rnd_tw(), rnd_tw());
          gstep(2'd1, rnd_data(), rnd_data(), rnd_tw(), rnd_tw());
        end
        for (int k = 0; k < DEPTH; k++)
          gstep(2'd2, rnd_data(), rnd_data(), rnd_tw(), rnd_tw());
      end
    end
    gap_en = 0;

    // Reset mid-frame: outputs clear at once, buffered samples are lost.
    for (int k = 0; k < DEPTH; k++)
      step(1, 2'd0, 24'(1000 + k), 24'(-5), 24'(0), 24'(0));
    step(1, 2'd1, 24'(3), 24'(3), 24'(0), 24'(0));
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    check("t1_rst_ov", 32'(out_valid), 32'd0);
    check("t1_rst_dr", 32'(dout_r), 32'd0);
    check("t1_rst_di", 32'(dout_i), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < DEPTH; k++) begin
      step(1, 2'd1, 24'(0), 24'(0), 24'(0), 24'(0));
      kexp("t1_post", 24'(0), 24'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
